afu_mmio_csr: RTL and testbench

- Avalon-MM MMIO slave that terminates the 64-bit host MMIO channel delivered to the AFU top level.
- Provides the mandatory AFU DFH and AFU_ID registers, a scratch register, and two mailbox FIFOs between host software and the soft RISC-V core:
  - host-to-core (H2C);
  - core-to-host (C2H).
- Sits directly downstream of the PIM host-channel-to-Avalon bridge, inside the afu wrapper.

---
 rtl/afu_mmio_csr_if.sv | 31 +++
 rtl/afu_mmio_csr.sv | 162 ++++++++++++++++
 tb/tb_afu_mmio_csr.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/afu_mmio_csr_if.sv
// ============================================================================
// Module : afu_mmio_csr_if
// Brief  : Avalon-MM 64-bit MMIO channel between the host bridge and the CSR block.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface afu_mmio_csr_if #(
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] address;
    logic                  read;
    logic                  write;
    logic [63:0]           writedata;
    logic [7:0]            byteenable;
    logic                  waitrequest;
    logic [63:0]           readdata;
    logic                  readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata, readdatavalid
    );
endinterface

`default_nettype wire

// File: rtl/afu_mmio_csr.sv
// ============================================================================
// Module : afu_mmio_csr
// Brief  : AFU MMIO CSR slave: DFH, AFU_ID, scratch and H2C/C2H mailbox FIFOs.
//          Optional free-running cycle counter at word 0x9 when
//          AFU_MMIO_CSR_CYCLE_CNT_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module afu_mmio_csr #(
    parameter int           ADDR_WIDTH = 16,
    parameter logic [127:0] AFU_ID     = 128'h0,
    parameter int           FIFO_DEPTH = 16
) (
    input  wire logic        clk,
    input  wire logic        reset,
    afu_mmio_csr_if.slave    avs,
    output logic [63:0]      h2c_data,
    output logic             h2c_valid,
    input  wire logic        h2c_ready,
    input  wire logic [63:0] c2h_data,
    input  wire logic        c2h_valid,
    output logic             c2h_ready
);
    localparam int c_aw    = $clog2(FIFO_DEPTH);
    localparam int c_ptr_w = c_aw + 1;
    localparam logic [63:0]           c_dfh         = 64'h1000_0100_0000_0000;
    localparam logic [ADDR_WIDTH-1:0] c_addr_dfh    = ADDR_WIDTH'('h0);
    localparam logic [ADDR_WIDTH-1:0] c_addr_id_l   = ADDR_WIDTH'('h1);
    localparam logic [ADDR_WIDTH-1:0] c_addr_id_h   = ADDR_WIDTH'('h2);
    localparam logic [ADDR_WIDTH-1:0] c_addr_scr    = ADDR_WIDTH'('h5);
    localparam logic [ADDR_WIDTH-1:0] c_addr_h2c    = ADDR_WIDTH'('h6);
    localparam logic [ADDR_WIDTH-1:0] c_addr_c2h    = ADDR_WIDTH'('h7);
    localparam logic [ADDR_WIDTH-1:0] c_addr_status = ADDR_WIDTH'('h8);
`ifdef AFU_MMIO_CSR_CYCLE_CNT_EN
    localparam logic [ADDR_WIDTH-1:0] c_addr_cnt    = ADDR_WIDTH'('h9);
`endif

    logic                waitreq_q;
    logic [63:0]         readdata_q;
    logic                rdvalid_q;
    logic [63:0]         scratch_q, scratch_d;
    logic                ovf_q, udf_q;
    logic [c_ptr_w-1:0]  h2c_wp_q, h2c_rp_q, c2h_wp_q, c2h_rp_q;
    logic [63:0]         h2c_mem_q [FIFO_DEPTH];
    logic [63:0]         c2h_mem_q [FIFO_DEPTH];

    logic                w_rd, w_wr;
    logic [c_ptr_w-1:0]  w_h2c_cnt, w_c2h_cnt;
    logic                w_h2c_full, w_c2h_full, w_h2c_empty, w_c2h_empty;
    logic                w_h2c_sel, w_h2c_push, w_h2c_pop, w_ovf_set;
    logic                w_c2h_sel, w_c2h_push, w_c2h_pop, w_udf_set;
    logic                w_stat_wr;
    logic [63:0]         w_rdata;

    // No transaction is accepted while the slave is still stalling after reset.
    assign w_rd = avs.read  & ~waitreq_q;
    assign w_wr = avs.write & ~waitreq_q;

    assign w_h2c_cnt   = h2c_wp_q - h2c_rp_q;
    assign w_c2h_cnt   = c2h_wp_q - c2h_rp_q;
    assign w_h2c_full  = (w_h2c_cnt == c_ptr_w'(FIFO_DEPTH));
    assign w_c2h_full  = (w_c2h_cnt == c_ptr_w'(FIFO_DEPTH));
    assign w_h2c_empty = (w_h2c_cnt == '0);
    assign w_c2h_empty = (w_c2h_cnt == '0);

    assign w_h2c_sel  = w_wr & (avs.address == c_addr_h2c) & (avs.byteenable == 8'hFF);
    assign w_h2c_push = w_h2c_sel & ~w_h2c_full;
    assign w_ovf_set  = w_h2c_sel & w_h2c_full;
    assign w_h2c_pop  = h2c_valid & h2c_ready;

    assign w_c2h_sel  = w_rd & (avs.address == c_addr_c2h);
    assign w_c2h_pop  = w_c2h_sel & ~w_c2h_empty;
    assign w_udf_set  = w_c2h_sel & w_c2h_empty;
    assign w_c2h_push = c2h_valid & c2h_ready;

    assign w_stat_wr  = w_wr & (avs.address == c_addr_status);

    assign h2c_valid = ~w_h2c_empty;
    assign h2c_data  = h2c_valid ? h2c_mem_q[h2c_rp_q[c_aw-1:0]] : 64'h0;
    assign c2h_ready = ~w_c2h_full & ~waitreq_q;

    assign avs.waitrequest   = waitreq_q;
    assign avs.readdata      = readdata_q;
    assign avs.readdatavalid = rdvalid_q;

`ifdef AFU_MMIO_CSR_CYCLE_CNT_EN
    logic [63:0] cnt_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else if (w_wr && (avs.address == c_addr_cnt))
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + 64'd1;
    end
`endif

    // Read mux sees registered state only, so a same-slot write is not visible.
    always_comb begin
        w_rdata = '0;
        case (avs.address)
            c_addr_dfh:    w_rdata = c_dfh;
            c_addr_id_l:   w_rdata = AFU_ID[63:0];
            c_addr_id_h:   w_rdata = AFU_ID[127:64];
            c_addr_scr:    w_rdata = scratch_q;
            c_addr_c2h:    w_rdata = w_c2h_empty ? 64'h0 : c2h_mem_q[c2h_rp_q[c_aw-1:0]];
            c_addr_status: w_rdata = {30'd0, udf_q, ovf_q, 16'(w_c2h_cnt), 16'(w_h2c_cnt)};
`ifdef AFU_MMIO_CSR_CYCLE_CNT_EN
            c_addr_cnt:    w_rdata = cnt_q;
`endif
            default:       w_rdata = '0;
        endcase
    end

    always_comb begin
        scratch_d = scratch_q;
        if (w_wr && (avs.address == c_addr_scr)) begin
            for (int i = 0; i < 8; i++) begin
                if (avs.byteenable[i])
                    scratch_d[8*i +: 8] = avs.writedata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            waitreq_q  <= 1'b1;
            readdata_q <= '0;
            rdvalid_q  <= 1'b0;
            scratch_q  <= '0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            h2c_wp_q   <= '0;
            h2c_rp_q   <= '0;
            c2h_wp_q   <= '0;
            c2h_rp_q   <= '0;
        end else begin
            waitreq_q <= 1'b0;
            rdvalid_q <= w_rd;
            if (w_rd)
                readdata_q <= w_rdata;
            scratch_q <= scratch_d;
            ovf_q     <= w_ovf_set | (ovf_q & ~(w_stat_wr & avs.writedata[32]));
            udf_q     <= w_udf_set | (udf_q & ~(w_stat_wr & avs.writedata[33]));
            if (w_h2c_push) h2c_wp_q <= h2c_wp_q + c_ptr_w'(1);
            if (w_h2c_pop)  h2c_rp_q <= h2c_rp_q + c_ptr_w'(1);
            if (w_c2h_push) c2h_wp_q <= c2h_wp_q + c_ptr_w'(1);
            if (w_c2h_pop)  c2h_rp_q <= c2h_rp_q + c_ptr_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_h2c_push)
            h2c_mem_q[h2c_wp_q[c_aw-1:0]] <= avs.writedata;
        if (w_c2h_push)
            c2h_mem_q[c2h_wp_q[c_aw-1:0]] <= c2h_data;
    end

endmodule

`default_nettype wire

// File: tb/tb_afu_mmio_csr.sv
// ============================================================================
// Module : tb_afu_mmio_csr
// Brief  : Randomised self-checking bench for afu_mmio_csr against a queue model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_afu_mmio_csr;
    localparam int           AW    = 16;
    localparam int           DEPTH = 16;
    localparam logic [127:0] ID    = 128'hAABB_0123_4567_89AB_FEDC_BA98_7654_CCDD;
    localparam logic [63:0]  DFH   = 64'h1000_0100_0000_0000;
`ifdef AFU_MMIO_CSR_CYCLE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] h2c_data;
    logic        h2c_valid;
    logic        h2c_ready = 1'b0;
    logic [63:0] c2h_data = '0;
    logic        c2h_valid = 1'b0;
    logic        c2h_ready;

    always #5 clk = ~clk;

    afu_mmio_csr_if #(.ADDR_WIDTH(AW)) avs_if ();

    afu_mmio_csr #(
        .ADDR_WIDTH (AW),
        .AFU_ID     (ID),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .avs       (avs_if.slave),
        .h2c_data  (h2c_data),
        .h2c_valid (h2c_valid),
        .h2c_ready (h2c_ready),
        .c2h_data  (c2h_data),
        .c2h_valid (c2h_valid),
        .c2h_ready (c2h_ready)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] h2c_q[$];
    logic [63:0] c2h_q[$];
    logic [63:0] m_scratch = '0;
    bit          m_ovf = 1'b0;
    bit          m_udf = 1'b0;
    logic [63:0] last_rd = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_read(input logic [15:0] a);
        case (a)
            16'h0:   return DFH;
            16'h1:   return ID[63:0];
            16'h2:   return ID[127:64];
            16'h5:   return m_scratch;
            16'h8:   return {30'd0, m_udf, m_ovf, 16'(c2h_q.size()), 16'(h2c_q.size())};
            default: return 64'h0;
        endcase
    endfunction

    // One bus slot: drive, predict from the model, clock, compare the response.
    task automatic cycle(input bit rd, input bit wr, input logic [15:0] a,
                         input logic [63:0] wd, input logic [7:0] be);
        logic [63:0] exp_rd;
        int hs, cs;
        bit ovf_set, udf_set;
        avs_if.read       = rd;
        avs_if.write      = wr;
        avs_if.address    = a;
        avs_if.writedata  = wd;
        avs_if.byteenable = be;
        hs = h2c_q.size();
        cs = c2h_q.size();
        check("h2c_valid", 64'(h2c_valid), 64'(hs != 0));
        if (hs != 0) check("h2c_data", h2c_data, h2c_q[0]);
        check("c2h_ready", 64'(c2h_ready), 64'(cs < DEPTH));
        exp_rd  = model_read(a);
        ovf_set = 1'b0;
        udf_set = 1'b0;
        if (rd && a == 16'h7) begin
            if (cs > 0) exp_rd = c2h_q.pop_front();
            else begin
                exp_rd  = 64'h0;
                udf_set = 1'b1;
            end
        end
        if (c2h_valid && cs < DEPTH) c2h_q.push_back(c2h_data);
        if (h2c_ready && hs > 0) void'(h2c_q.pop_front());
        if (wr) begin
            case (a)
                16'h5: for (int i = 0; i < 8; i++) if (be[i]) m_scratch[8*i +: 8] = wd[8*i +: 8];
                16'h6: if (be == 8'hFF) begin
                           if (hs < DEPTH) h2c_q.push_back(wd);
                           else ovf_set = 1'b1;
                       end
                16'h8: begin
                           if (wd[32]) m_ovf = 1'b0;
                           if (wd[33]) m_udf = 1'b0;
                       end
                default: ;
            endcase
        end
        if (ovf_set) m_ovf = 1'b1;
        if (udf_set) m_udf = 1'b1;
        @(posedge clk);
        #1;
        check("rdvalid", 64'(avs_if.readdatavalid), 64'(rd));
        if (rd) begin
            last_rd = avs_if.readdata;
            if (a != 16'h9 || !CNT_EN) check($sformatf("rd[%0h]", a), avs_if.readdata, exp_rd);
        end
        avs_if.read  = 1'b0;
        avs_if.write = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0, 16'h0, 64'h0, 8'h0);
    endtask

    task automatic rd(input logic [15:0] a);
        cycle(1'b1, 1'b0, a, 64'h0, 8'h0);
    endtask

    task automatic wr(input logic [15:0] a, input logic [63:0] d, input logic [7:0] be);
        cycle(1'b0, 1'b1, a, d, be);
    endtask

    task automatic release_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("waitreq_after_rst", 64'(avs_if.waitrequest), 64'h0);
    endtask

    initial begin
        logic [15:0] addrs [10] = '{16'h0, 16'h1, 16'h2, 16'h3, 16'h5, 16'h6, 16'h7, 16'h8, 16'h9, 16'hF};
        logic [63:0] r1;
        avs_if.read = 1'b0;
        avs_if.write = 1'b0;
        avs_if.address = '0;
        avs_if.writedata = '0;
        avs_if.byteenable = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_waitreq", 64'(avs_if.waitrequest), 64'h1);
        check("rst_rdvalid", 64'(avs_if.readdatavalid), 64'h0);
        check("rst_readdata", avs_if.readdata, 64'h0);
        check("rst_h2c_valid", 64'(h2c_valid), 64'h0);
        check("rst_h2c_data", h2c_data, 64'h0);
        check("rst_c2h_ready", 64'(c2h_ready), 64'h0);
        release_reset();

        rd(16'h0); rd(16'h1); rd(16'h2); rd(16'h3); rd(16'h8);
        wr(16'h5, 64'h1122334455667788, 8'h0F);
        rd(16'h5);
        check("scratch_be0f", last_rd, 64'h0000000055667788);

        for (int v = 1; v <= 17; v++) wr(16'h6, 64'(v), 8'hFF);
        rd(16'h8);
        check("h2c_full_occ", 64'(last_rd[15:0]), 64'd16);
        check("h2c_ovf_flag", 64'(last_rd[32]), 64'h1);
        h2c_ready = 1'b1;
        idle(17);
        rd(16'h8);
        h2c_ready = 1'b0;
        wr(16'h8, 64'h1 << 32, 8'hFF);
        rd(16'h8);
        check("ovf_w1c", 64'(last_rd[32]), 64'h0);

        wr(16'h6, 64'hDEAD, 8'hFE);
        rd(16'h8);

        for (int i = 0; i < 40; i++) begin
            c2h_valid = 1'b1;
            c2h_data  = 64'd1000 + 64'(i);
            cycle(i > 0, 1'b0, 16'h7, 64'h0, 8'h0);
        end
        c2h_valid = 1'b0;
        rd(16'h7);
        rd(16'h7);
        check("c2h_empty_rd", last_rd, 64'h0);
        rd(16'h8);
        check("udf_flag", 64'(last_rd[33]), 64'h1);
        wr(16'h8, 64'h3 << 32, 8'hFF);

        c2h_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            c2h_data = 64'hC0DE_0000 + 64'(i);
            idle(1);
        end
        c2h_data = 64'hC0DE_0005;
        rd(16'h7);
        c2h_valid = 1'b0;
        rd(16'h8);
        check("c2h_pushpop_occ", 64'(last_rd[31:16]), 64'd5);

        for (int n = 0; n < 400; n++) begin
            h2c_ready = 1'($urandom_range(0, 1));
            c2h_valid = 1'($urandom_range(0, 1));
            c2h_data  = {$urandom, $urandom};
            cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                  addrs[$urandom_range(0, 9)], {$urandom, $urandom},
                  ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom));
        end

        h2c_ready = 1'b0;
        c2h_valid = 1'b0;
        wr(16'h5, 64'hFEED_FACE_CAFE_BEEF, 8'hFF);
        idle(1);
        while (h2c_q.size() > 0) begin h2c_ready = 1'b1; idle(1); end
        h2c_ready = 1'b0;
        for (int i = 0; i < 3; i++) wr(16'h6, 64'hA0 + 64'(i), 8'hFF);
        avs_if.read    = 1'b1;
        avs_if.address = 16'h5;
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_rdvalid", 64'(avs_if.readdatavalid), 64'h0);
        avs_if.read = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_rdvalid2", 64'(avs_if.readdatavalid), 64'h0);
        check("rst_mid_h2c_valid", 64'(h2c_valid), 64'h0);
        h2c_q.delete();
        c2h_q.delete();
        m_scratch = '0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        release_reset();
        rd(16'h8);
        rd(16'h5);

        if (CNT_EN) begin
            rd(16'h9);
            r1 = last_rd;
            idle(9);
            rd(16'h9);
            check("cnt_delta", last_rd - r1, 64'd10);
            wr(16'h9, 64'h1234, 8'hFF);
            rd(16'h9);
            check("cnt_clear", last_rd, 64'h0);
        end else begin
            wr(16'h9, 64'h1234, 8'hFF);
            rd(16'h9);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
